// File: rtl/switch_debounce.sv
// Slide-switch conditioner: per-bit 2-FF synchronizer followed by a stability
// counter, with registered rise/fall/any-change strobes.
module switch_debounce #(
  parameter int WIDTH   = 8,
  parameter int CNT_MAX = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] switch,
  output logic [WIDTH-1:0] switch_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  //  state      | meaning
  //  ST_STABLE  | synchronized input agrees with switch_db, counter idle at 0
  //  ST_PENDING | input disagrees; counter holds consecutive disagreeing cycles

  localparam int               CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] db_q;
  logic [WIDTH-1:0] db_d;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;
  logic             changed_q;
  logic             changed_d;
  state_e           state_q [WIDTH];
  state_e           state_d [WIDTH];
  logic [CNT_W-1:0] cnt_q   [WIDTH];
  logic [CNT_W-1:0] cnt_d   [WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q   <= switch;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    db_d    = db_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      case (state_q[i])
        ST_STABLE: begin
          if (sync2_q[i] != db_q[i]) begin
            // A one-cycle stability requirement commits on the first disagreement.
            if (CNT_MAX == 1) begin
              db_d[i] = sync2_q[i];
            end else begin
              state_d[i] = ST_PENDING;
              cnt_d[i]   = CNT_ONE;
            end
          end
        end
        ST_PENDING: begin
          if (sync2_q[i] == db_q[i]) begin
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            db_d[i]    = sync2_q[i];
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = ST_STABLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
    rise_d    = db_d & ~db_q;
    fall_d    = ~db_d & db_q;
    changed_d = |(rise_d | fall_d);
  end

  assign switch_db  = db_q;
  assign sw_rise    = rise_q;
  assign sw_fall    = fall_q;
  assign sw_changed = changed_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce: a window-based reference model pushes
// the expected outputs per edge; a monitor pops and compares after each edge.
module tb_switch_debounce;

  localparam int WIDTH   = 8;
  localparam int CNT_MAX = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] switch_r;
  logic [WIDTH-1:0] switch_db;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             sw_changed;

  int vectors = 0;
  int errors  = 0;

  // expected {switch_db, sw_rise, sw_fall, sw_changed} per clock edge
  logic [3*WIDTH:0] exp_q [$];

  switch_debounce #(.WIDTH(WIDTH), .CNT_MAX(CNT_MAX)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .switch     (switch_r),
    .switch_db  (switch_db),
    .sw_rise    (sw_rise),
    .sw_fall    (sw_fall),
    .sw_changed (sw_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: raw samples reach the debouncer two edges late; a bit
  // flips once the last CNT_MAX delayed samples since reset all disagree with it.
  initial begin : model
    logic [WIDTH-1:0] raw_hist [$];
    logic [WIDTH-1:0] s2_hist  [$];
    logic [WIDTH-1:0] m_db;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] s2;
    bit               all_diff;
    m_db = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        raw_hist.delete();
        raw_hist.push_back('0);
        raw_hist.push_back('0);
        s2_hist.delete();
        m_db = '0;
        exp_q.push_back('0);
      end else begin
        raw_hist.push_back(switch_r);
        s2 = raw_hist[raw_hist.size() - 3];
        if (raw_hist.size() > 3) void'(raw_hist.pop_front());
        s2_hist.push_back(s2);
        if (s2_hist.size() > CNT_MAX) void'(s2_hist.pop_front());
        nxt = m_db;
        if (s2_hist.size() == CNT_MAX) begin
          for (int b = 0; b < WIDTH; b++) begin
            all_diff = 1'b1;
            foreach (s2_hist[k]) if (s2_hist[k][b] == m_db[b]) all_diff = 1'b0;
            if (all_diff) nxt[b] = ~m_db[b];
          end
        end
        exp_q.push_back({nxt, nxt & ~m_db, ~nxt & m_db, |(nxt ^ m_db)});
        m_db = nxt;
      end
    end
  end

  initial begin : monitor
    logic [3*WIDTH:0] got;
    logic [3*WIDTH:0] want;
    forever begin
      @(posedge clk);
      #1;
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t: DUT output present but no expected entry", $time);
      end else begin
        want = exp_q.pop_front();
        got  = {switch_db, sw_rise, sw_fall, sw_changed};
        if (got !== want) begin
          errors++;
          $display("FAIL outputs t=%0t: db got %h want %h, rise got %h want %h, fall got %h want %h, changed got %b want %b",
                   $time, got[3*WIDTH -: WIDTH], want[3*WIDTH -: WIDTH],
                   got[2*WIDTH -: WIDTH], want[2*WIDTH -: WIDTH],
                   got[WIDTH -: WIDTH], want[WIDTH -: WIDTH], got[0], want[0]);
        end
      end
    end
  end

  task automatic hold(input logic [WIDTH-1:0] v, input int n);
    for (int k = 0; k < n; k++) begin
      switch_r = v;
      @(negedge clk);
    end
  endtask

  initial begin : stimulus
    logic [WIDTH-1:0] cur;
    int               mode;
    rst_n    = 1'b0;
    switch_r = 8'hFF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // power-up with one switch already high
    hold(8'h01, 10);
    // short glitch on bit 3
    hold(8'h09, 3);
    hold(8'h01, 10);
    // bounce on bit 2 before settling high
    hold(8'h05, 1);
    hold(8'h01, 1);
    hold(8'h05, 12);
    // four bits rise and four fall on the same edge
    hold(8'h0F, 10);
    hold(8'hF0, 10);
    // reset in the middle of a pending count
    hold(8'h00, 10);
    hold(8'h01, 4);
    rst_n = 1'b0;
    hold(8'h01, 2);
    rst_n = 1'b1;
    hold(8'h01, 12);

    // randomized bouncing, mixing long holds with sub-threshold glitches
    cur = 8'h01;
    for (int seg = 0; seg < 600; seg++) begin
      mode = int'($urandom_range(0, 3));
      if (mode == 0)      cur = WIDTH'($urandom);
      else if (mode != 3) cur[$urandom_range(0, WIDTH - 1)] ^= 1'b1;
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        hold(cur, int'($urandom_range(1, 3)));
        rst_n = 1'b1;
      end
      hold(cur, int'($urandom_range(1, 2 * CNT_MAX + 2)));
    end
    hold(cur, 2 * CNT_MAX + 4);

    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
